// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter slice.
// Holds the FSM state encoding and the default geometry / timing limits so
// the top level, the watchdog and the testbench all agree on them.
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_STARVE_MAX = 4;

  // States are plain encoded constants so older tools and scripts that
  // decode the state register by value keep working.
  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t BUSY_IF  = 3'd1;
  localparam state_t BUSY_MEM = 3'd2;
  localparam state_t RESP_IF  = 3'd3;
  localparam state_t RESP_MEM = 3'd4;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog for the arbiter.
// Counts cycles while en is high and flags expired combinationally on the
// TIMEOUT-th such cycle, so the owner can leave its wait state on the very
// next edge.
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low reset
//   en      - count this cycle (waiting on the bus, no ack)
//   clr     - restart the count (owner is not waiting)
//   expired - this is the TIMEOUT-th waiting cycle
module mem_arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of waiting cycles already completed, so the
  // current cycle is the TIMEOUT-th when cnt reaches TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter.
// Arbitrates an instruction-fetch (IF, read only) port and a data (MEM,
// read/write) port onto a single request/ack bus. MEM normally wins, but an
// IF port that has watched STARVE_MAX consecutive MEM grants wins next.
// Each transaction is BUSY (bus_req_o held) until bus_ack_i or watchdog
// expiry, then one RESP cycle with the port's done pulse, then IDLE.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   if_*                - IF request, address, read data, done/err/stall
//   mem_*               - MEM request, we, address, wdata, wstrb,
//                         read data, done/err/stall
//   bus_*               - shared bus request/payload out, ack/rdata in
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  output logic                if_err_o,
  output logic                if_stall_o,

  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                mem_err_o,
  output logic                mem_stall_o,

  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          busy;
  logic          grant_mem;
  logic          grant_if;
  logic          wd_en;
  logic          wd_clr;
  logic          wd_expired;

  // Arbitration is only acted on in IDLE. MEM wins unless IF has been
  // waiting through STARVE_MAX MEM grants. The watchdog only runs while a
  // BUSY state waits without an ack, and restarts otherwise.
  always_comb begin
    busy      = (state == BUSY_IF) || (state == BUSY_MEM);
    grant_mem = mem_req_i && !(if_req_i && (starve_cnt == STARVE_LIM));
    grant_if  = if_req_i && !grant_mem;
    wd_en     = busy && !bus_ack_i;
    wd_clr    = !busy;
  end

  // Stall is the only combinational output: the master sees it drop in
  // the same cycle its done pulse arrives.
  assign if_stall_o  = if_req_i  && !if_done_o;
  assign mem_stall_o = mem_req_i && !mem_done_o;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wd_en),
    .clr     (wd_clr),
    .expired (wd_expired)
  );

  // Starvation counter: tracks MEM grants taken while IF was asking.
  // It only means anything while IF keeps asking, so it clears as soon
  // as IF drops its request or finally gets the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req_i) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && grant_if) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && grant_mem && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Main FSM and registered outputs. Done/err are one-cycle pulses that
  // coincide with the RESP state. The bus payload registers are loaded
  // at grant and left untouched until the next grant, which keeps them
  // stable through the whole BUSY period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
      if_rdata_o  <= '0;
      if_done_o   <= 1'b0;
      if_err_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      mem_err_o   <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      if_err_o   <= 1'b0;
      mem_done_o <= 1'b0;
      mem_err_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_mem) begin
            state       <= BUSY_MEM;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            bus_wstrb_o <= mem_wstrb_i;
          end else if (grant_if) begin
            // IF is fetch-only: never drive a write or byte strobes.
            state       <= BUSY_IF;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
          end
        end

        BUSY_IF: begin
          if (bus_ack_i) begin
            state      <= RESP_IF;
            bus_req_o  <= 1'b0;
            if_rdata_o <= bus_rdata_i;
            if_done_o  <= 1'b1;
          end else if (wd_expired) begin
            state      <= RESP_IF;
            bus_req_o  <= 1'b0;
            if_rdata_o <= '0;
            if_done_o  <= 1'b1;
            if_err_o   <= 1'b1;
          end
        end

        BUSY_MEM: begin
          if (bus_ack_i) begin
            state       <= RESP_MEM;
            bus_req_o   <= 1'b0;
            mem_rdata_o <= bus_rdata_i;
            mem_done_o  <= 1'b1;
          end else if (wd_expired) begin
            state       <= RESP_MEM;
            bus_req_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b1;
            mem_err_o   <= 1'b1;
          end
        end

        RESP_IF, RESP_MEM: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
